vp_spec_ctrl: RTL and testbench
===============================

VP_SPEC_CTRL -- requirements
Module: vp_spec_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of load values.
REQ-002 SHALL have parameter PC_WIDTH, default 32: width of load PC tag.
REQ-003 SHALL have parameter DEPTH, default 4: max outstanding predicted loads; power of 2, >=1.
REQ-004 SHALL have parameter CNT_W, default 16: statistics counter width.
REQ-005 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port vp_enable  in  1  global prediction enable.
REQ-008 SHALL have port ld_valid  in  1  load in MEM requesting speculation.
REQ-009 SHALL have port ld_pc  in  PC_WIDTH  PC of that load.
REQ-010 SHALL have port pred_valid  in  1  predictor has a value for ld_pc this cycle.
REQ-011 SHALL have port pred_data  in  DATA_WIDTH  predicted value.
REQ-012 SHALL have port ld_accept  out  1  load allocated as speculative (combinational).
REQ-013 SHALL have port spec_valid  out  1  registered; predicted value available.
REQ-014 SHALL have port spec_data  out  DATA_WIDTH  registered predicted value.
REQ-015 SHALL have port snap_take  out  1  pulse: take register snapshot.
REQ-016 SHALL have port snap_id  out  $clog2(DEPTH) (min 1)  slot for snapshot.
REQ-017 SHALL have port res_valid  in  1  oldest outstanding load resolved by D-cache.
REQ-018 SHALL have port res_data  in  DATA_WIDTH  actual loaded value.
REQ-019 SHALL have port recover  out  1  pulse: restore snapshot recover_id.
REQ-020 SHALL have port recover_id  out  $clog2(DEPTH) (min 1)  slot to restore.
REQ-021 SHALL have port recovery_done  in  1  register file restore complete.
REQ-022 SHALL have port stall  out  1  override stall for all stages.
REQ-023 SHALL have port flush  out  1  override flush for all stages.
REQ-024 SHALL have port occupancy  out  $clog2(DEPTH+1)  outstanding entries.
REQ-025 SHALL have ports cnt_hit, cnt_miss  out  CNT_W each  correct/incorrect prediction counts.

Function
REQ-026 SHALL implement FSM IDLE (occupancy 0), SPEC (occupancy>0), RECOVER.
REQ-027 SHALL assert ld_accept = ld_valid & pred_valid & vp_enable & state!=RECOVER & occupancy<DEPTH (registered occupancy).
REQ-028 On accept SHALL write {ld_pc, pred_data} at tail, pulse snap_take with snap_id=tail in the same cycle, increment tail mod DEPTH.
REQ-029 SHALL drive spec_valid=1, spec_data=pred_data exactly one cycle after accept; otherwise spec_valid=0.
REQ-030 SHALL assert stall when ld_valid & pred_valid & vp_enable & ~ld_accept (full or RECOVER), and for every cycle in RECOVER.
REQ-031 ld_valid with pred_valid=0 or vp_enable=0 SHALL proceed non-speculatively: no accept, no stall.
REQ-032 On res_valid with occupancy>0 SHALL compare res_data to head value: equal -> pop head, cnt_hit+1.
REQ-033 Mismatch SHALL, same cycle, pulse recover and flush with recover_id=head slot, cnt_miss+1; next cycle occupancy=0, head=tail, state=RECOVER, discarding all younger entries.
REQ-034 res_valid with occupancy 0 SHALL be ignored; no counter or state change.
REQ-035 Accept and hit-retire in one cycle SHALL both occur; occupancy unchanged.
REQ-036 Mispredict and ld_valid in one cycle: ld_accept SHALL be 0 and stall 1.
REQ-037 In RECOVER, recovery_done SHALL move state to IDLE next cycle; stall deasserts that cycle.
REQ-038 Counters SHALL saturate at 2^CNT_W-1.
REQ-039 vp_enable falling with entries outstanding SHALL still resolve them normally.

Reset
REQ-040 rst SHALL force IDLE, head=tail=0, occupancy=0, cnt_hit=cnt_miss=0, spec_valid=0; all pulse outputs 0, regardless of state (including mid-RECOVER).
REQ-041 Entry storage contents need not reset.

Structure
REQ-042 Package vp_pkg SHALL hold the state enum and default parameter constants.
REQ-043 Circular entry buffer SHALL be sub-module vp_entry_fifo (push, pop, clear, head data, occupancy).

Verification
REQ-044 DEPTH=4: accept load pc=0x100 pred=0xA, res_data=0xA -> snap_id=0, spec_data=0xA next cycle, cnt_hit=1, IDLE.
REQ-045 4 accepts then 5th ld_valid -> ld_accept=0, stall=1; hit-retire frees slot -> 5th accepted, snap_id=0 (wrap).
REQ-046 3 outstanding, res_data mismatches head slot 1 -> recover=1, recover_id=1, flush=1 one cycle, occupancy 0, stall until recovery_done.
REQ-047 Accept + hit on same cycle with occupancy 2 -> occupancy stays 2.
REQ-048 rst asserted during RECOVER -> next cycle IDLE, stall=0, counters 0.
REQ-049 CNT_W=2, 5 hits -> cnt_hit=3.

Source files
------------

// File: rtl/vp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vp_pkg
//  Description : Shared types and default constants for the load value
//                prediction speculation controller.
//                  - vp_state_e : controller FSM state
//                  - ptr_w()    : slot-index width for a given depth
//                                 (never narrower than 1 bit)
//  Revision    : 1.0 - initial release
// ============================================================================
package vp_pkg;

    localparam int c_data_width_def = 32;
    localparam int c_pc_width_def   = 32;
    localparam int c_depth_def      = 4;
    localparam int c_cnt_w_def      = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SPEC    = 2'd1,
        ST_RECOVER = 2'd2
    } vp_state_e;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vp_entry_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : vp_entry_fifo
//  Description : Circular buffer of outstanding predicted loads, {pc, value}.
//                Ports:
//                  i_push/i_push_pc/i_push_data : allocate entry at tail
//                  i_pop                        : retire head entry
//                  i_clear                      : discard all (head <= tail)
//                  o_head_data / o_head_pc      : oldest entry contents
//                  o_head_ptr / o_tail_ptr      : slot indices
//                  o_occupancy                  : number of live entries
//  Revision    : 1.0 - initial release
// ============================================================================
module vp_entry_fifo
    import vp_pkg::*;
#(
    parameter int DATA_WIDTH = c_data_width_def,
    parameter int PC_WIDTH   = c_pc_width_def,
    parameter int DEPTH      = c_depth_def,
    parameter int PTR_W      = ptr_w(DEPTH),
    parameter int OCC_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [PC_WIDTH-1:0]   i_push_pc,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    input  logic                  i_clear,
    output logic [DATA_WIDTH-1:0] o_head_data,
    output logic [PC_WIDTH-1:0]   o_head_pc,
    output logic [PTR_W-1:0]      o_head_ptr,
    output logic [PTR_W-1:0]      o_tail_ptr,
    output logic [OCC_W-1:0]      o_occupancy
);

    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [PC_WIDTH-1:0]   r_pc   [DEPTH];
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [OCC_W-1:0]      r_count;
    logic [PTR_W-1:0]      w_head_inc;
    logic [PTR_W-1:0]      w_tail_inc;

    // Explicit wrap keeps the modulo correct even when DEPTH does not fill
    // the pointer's binary range (DEPTH == 1).
    always_comb begin
        w_head_inc = (r_head == PTR_W'(DEPTH - 1)) ? '0 : r_head + 1'b1;
        w_tail_inc = (r_tail == PTR_W'(DEPTH - 1)) ? '0 : r_tail + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            // Younger entries are squashed; tail stays, so the next
            // allocation continues from the same slot sequence.
            r_head  <= r_tail;
            r_count <= '0;
        end else begin
            if (i_push) r_tail <= w_tail_inc;
            if (i_pop)  r_head <= w_head_inc;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage carries no reset; validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_data[r_tail] <= i_push_data;
            r_pc[r_tail]   <= i_push_pc;
        end
    end

    assign o_head_data = r_data[r_head];
    assign o_head_pc   = r_pc[r_head];
    assign o_head_ptr  = r_head;
    assign o_tail_ptr  = r_tail;
    assign o_occupancy = r_count;

endmodule
`default_nettype wire

// File: rtl/vp_spec_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : vp_spec_ctrl
//  Description : Load value prediction speculation controller.
//                Inputs : clk, rst, vp_enable, ld_valid/ld_pc,
//                         pred_valid/pred_data, res_valid/res_data,
//                         recovery_done
//                Outputs: ld_accept, spec_valid/spec_data, snap_take/snap_id,
//                         recover/recover_id, stall, flush, occupancy,
//                         cnt_hit, cnt_miss
//  Revision    : 1.0 - initial release
// ============================================================================
module vp_spec_ctrl
    import vp_pkg::*;
#(
    parameter int DATA_WIDTH = c_data_width_def,
    parameter int PC_WIDTH   = c_pc_width_def,
    parameter int DEPTH      = c_depth_def,
    parameter int CNT_W      = c_cnt_w_def
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        vp_enable,
    input  logic                        ld_valid,
    input  logic [PC_WIDTH-1:0]         ld_pc,
    input  logic                        pred_valid,
    input  logic [DATA_WIDTH-1:0]       pred_data,
    output logic                        ld_accept,
    output logic                        spec_valid,
    output logic [DATA_WIDTH-1:0]       spec_data,
    output logic                        snap_take,
    output logic [ptr_w(DEPTH)-1:0]     snap_id,
    input  logic                        res_valid,
    input  logic [DATA_WIDTH-1:0]       res_data,
    output logic                        recover,
    output logic [ptr_w(DEPTH)-1:0]     recover_id,
    input  logic                        recovery_done,
    output logic                        stall,
    output logic                        flush,
    output logic [$clog2(DEPTH+1)-1:0]  occupancy,
    output logic [CNT_W-1:0]            cnt_hit,
    output logic [CNT_W-1:0]            cnt_miss
);

    localparam int c_ptr_w = ptr_w(DEPTH);
    localparam int c_occ_w = $clog2(DEPTH + 1);

    vp_state_e             r_state;
    vp_state_e             w_state_nxt;
    logic                  r_spec_valid;
    logic [DATA_WIDTH-1:0] r_spec_data;
    logic [CNT_W-1:0]      r_cnt_hit;
    logic [CNT_W-1:0]      r_cnt_miss;

    logic [DATA_WIDTH-1:0] w_head_data;
    logic [PC_WIDTH-1:0]   w_unused_head_pc;
    logic [c_ptr_w-1:0]    w_head_ptr;
    logic [c_ptr_w-1:0]    w_tail_ptr;
    logic [c_occ_w-1:0]    w_occ;
    logic                  w_spec_req;
    logic                  w_resolve;
    logic                  w_hit;
    logic                  w_mispredict;
    logic                  w_accept;
    logic                  w_occ_nxt_nz;

    vp_entry_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .PC_WIDTH   (PC_WIDTH),
        .DEPTH      (DEPTH),
        .PTR_W      (c_ptr_w),
        .OCC_W      (c_occ_w)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_accept),
        .i_push_pc   (ld_pc),
        .i_push_data (pred_data),
        .i_pop       (w_hit),
        .i_clear     (w_mispredict),
        .o_head_data (w_head_data),
        .o_head_pc   (w_unused_head_pc),
        .o_head_ptr  (w_head_ptr),
        .o_tail_ptr  (w_tail_ptr),
        .o_occupancy (w_occ)
    );

    // Pulses are gated by rst so nothing leaks out during a reset cycle.
    // A mispredict squashes the whole window, so a same-cycle allocation
    // is refused and the requesting load stalls instead.
    always_comb begin
        w_spec_req   = ld_valid & pred_valid & vp_enable;
        w_resolve    = ~rst & res_valid & (w_occ != '0);
        w_hit        = w_resolve & (res_data == w_head_data);
        w_mispredict = w_resolve & (res_data != w_head_data);
        w_accept     = ~rst & w_spec_req & (r_state != ST_RECOVER)
                     & (w_occ < c_occ_w'(DEPTH)) & ~w_mispredict;
        w_occ_nxt_nz = w_accept | (w_occ > c_occ_w'(1))
                     | ((w_occ == c_occ_w'(1)) & ~w_hit);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RECOVER: if (recovery_done) w_state_nxt = ST_IDLE;
            default: begin
                if (w_mispredict)      w_state_nxt = ST_RECOVER;
                else if (w_occ_nxt_nz) w_state_nxt = ST_SPEC;
                else                   w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_spec_valid <= 1'b0;
            r_cnt_hit    <= '0;
            r_cnt_miss   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_spec_valid <= w_accept;
            if (w_hit && (r_cnt_hit != '1))
                r_cnt_hit <= r_cnt_hit + 1'b1;
            if (w_mispredict && (r_cnt_miss != '1))
                r_cnt_miss <= r_cnt_miss + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) r_spec_data <= pred_data;
    end

    assign ld_accept  = w_accept;
    assign snap_take  = w_accept;
    assign snap_id    = w_tail_ptr;
    assign recover    = w_mispredict;
    assign flush      = w_mispredict;
    assign recover_id = w_head_ptr;
    assign stall      = (r_state == ST_RECOVER) | (w_spec_req & ~w_accept);
    assign spec_valid = r_spec_valid;
    assign spec_data  = r_spec_data;
    assign occupancy  = w_occ;
    assign cnt_hit    = r_cnt_hit;
    assign cnt_miss   = r_cnt_miss;

endmodule
`default_nettype wire

// File: tb/tb_vp_spec_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vp_spec_ctrl
//  Description : Scoreboard bench for vp_spec_ctrl. A queue-based model of
//                the outstanding-load window predicts each cycle's outputs;
//                a negedge monitor pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vp_spec_ctrl;

    localparam int DW    = 8;
    localparam int PW    = 16;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          vp_enable = 1'b0, ld_valid = 1'b0, pred_valid = 1'b0;
    logic [PW-1:0] ld_pc = '0;
    logic [DW-1:0] pred_data = '0, res_data = '0;
    logic          res_valid = 1'b0, recovery_done = 1'b0;
    logic          ld_accept, spec_valid, snap_take, recover, stall, flush;
    logic [DW-1:0] spec_data;
    logic [1:0]    snap_id, recover_id;
    logic [2:0]    occupancy;
    logic [CNT_W-1:0] cnt_hit, cnt_miss;

    vp_spec_ctrl #(.DATA_WIDTH(DW), .PC_WIDTH(PW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .vp_enable(vp_enable), .ld_valid(ld_valid),
        .ld_pc(ld_pc), .pred_valid(pred_valid), .pred_data(pred_data),
        .ld_accept(ld_accept), .spec_valid(spec_valid), .spec_data(spec_data),
        .snap_take(snap_take), .snap_id(snap_id), .res_valid(res_valid),
        .res_data(res_data), .recover(recover), .recover_id(recover_id),
        .recovery_done(recovery_done), .stall(stall), .flush(flush),
        .occupancy(occupancy), .cnt_hit(cnt_hit), .cnt_miss(cnt_miss)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit chk;
        bit acc;
        bit stl;
        int sid;
        bit mis;
        int rid;
        bit sv;
        int occ;
        int hits;
        int misses;
    } exp_t;

    exp_t exp_q[$];
    int   spec_q[$];

    // Reference model: window of predicted values, oldest first
    int mq[$];
    int m_head = 0, m_tail = 0, m_hits = 0, m_misses = 0;
    bit m_rec = 0, m_prev_acc = 0;

    int n_chk = 0, n_fail = 0;

    task automatic check(input string name, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    // One clock of stimulus: drive inputs, push expected response, advance model
    task automatic step(input bit r, input bit lv, input bit pv, input bit en,
                        input int pc, input int pd, input bit rv, input int rd,
                        input bit done);
        exp_t e;
        int   occ;
        bit   req, resolve, mis, hit, acc;
        @(posedge clk);
        #1;
        rst = r; ld_valid = lv; pred_valid = pv; vp_enable = en;
        ld_pc = PW'(pc); pred_data = DW'(pd); res_valid = rv;
        res_data = DW'(rd); recovery_done = done;
        e = '{default: 0};
        if (r) begin
            e.chk = 0;
            exp_q.push_back(e);
            mq.delete();
            m_head = 0; m_tail = 0; m_hits = 0; m_misses = 0;
            m_rec = 0; m_prev_acc = 0;
            return;
        end
        occ     = mq.size();
        req     = lv && pv && en;
        resolve = rv && occ > 0;
        mis     = resolve && (rd != mq[0]);
        hit     = resolve && !mis;
        acc     = req && !m_rec && occ < DEPTH && !mis;
        e.chk = 1; e.acc = acc; e.stl = m_rec || (req && !acc);
        e.sid = m_tail; e.mis = mis; e.rid = m_head; e.sv = m_prev_acc;
        e.occ = occ; e.hits = m_hits; e.misses = m_misses;
        exp_q.push_back(e);
        if (acc) spec_q.push_back(pd);
        if (m_rec && done) m_rec = 0;
        if (mis) begin
            mq.delete();
            m_head = m_tail;
            m_rec = 1;
            if (m_misses < CMAX) m_misses++;
        end else begin
            if (hit) begin
                void'(mq.pop_front());
                m_head = (m_head + 1) % DEPTH;
                if (m_hits < CMAX) m_hits++;
            end
            if (acc) begin
                mq.push_back(pd);
                m_tail = (m_tail + 1) % DEPTH;
            end
        end
        m_prev_acc = acc;
    endtask

    task automatic idle(input bit done);
        step(0, 0, 0, 0, 0, 0, 0, 0, done);
    endtask

    task automatic load(input int pc, input int pd);
        step(0, 1, 1, 1, pc, pd, 0, 0, 0);
    endtask

    task automatic resolve_v(input int rd);
        step(0, 0, 0, 0, 0, 0, 1, rd, 0);
    endtask

    exp_t me;
    always @(negedge clk) begin
        if (spec_valid) begin
            if (spec_q.size() == 0) check("spec_valid_unexpected", 1, 0);
            else check("spec_data", int'(spec_data), spec_q.pop_front());
        end
        if (exp_q.size() > 0) begin
            me = exp_q.pop_front();
            if (me.chk) begin
                check("ld_accept", int'(ld_accept), int'(me.acc));
                check("snap_take", int'(snap_take), int'(me.acc));
                if (me.acc) check("snap_id", int'(snap_id), me.sid);
                check("stall", int'(stall), int'(me.stl));
                check("recover", int'(recover), int'(me.mis));
                check("flush", int'(flush), int'(me.mis));
                if (me.mis) check("recover_id", int'(recover_id), me.rid);
                check("spec_valid", int'(spec_valid), int'(me.sv));
                check("occupancy", int'(occupancy), me.occ);
                check("cnt_hit", int'(cnt_hit), me.hits);
                check("cnt_miss", int'(cnt_miss), me.misses);
            end
        end
    end

    initial begin
        int lv, pv, en, rv, rd, dn;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 1, 0, 0, 1, 0, 0);

        // Single hit: slot 0, value 0xA
        load('h100, 'hA);
        resolve_v('hA);
        idle(0);

        // Fill to DEPTH, 5th stalls, hit frees a slot, 5th wraps to slot 0
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) load('h200 + i, 16 + i);
        load('h300, 99);
        step(0, 1, 1, 1, 'h300, 99, 1, 16, 0);
        load('h300, 99);
        idle(0);

        // Three outstanding with head at slot 1, mispredict, recovery
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) load('h400 + i, 40 + i);
        resolve_v(40);
        step(0, 1, 1, 1, 'h500, 7, 1, 200, 0);
        load('h501, 8);
        idle(0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(0);
        load('h502, 9);

        // Accept and hit together at occupancy 2
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        load('h600, 1);
        load('h601, 2);
        step(0, 1, 1, 1, 'h602, 3, 1, 1, 0);
        idle(0);

        // Reset while in RECOVER
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        load('h700, 5);
        resolve_v(6);
        load('h701, 6);
        step(1, 1, 1, 1, 0, 0, 0, 0, 0);
        load('h702, 7);
        idle(0);

        // Prediction disabled with entries outstanding still resolves
        load('h800, 11);
        step(0, 1, 1, 0, 'h801, 12, 1, 7, 0);
        step(0, 1, 0, 1, 'h802, 13, 1, 11, 0);
        idle(0);

        // Randomised run; counters saturate at CMAX along the way
        for (int c = 0; c < 3000; c++) begin
            lv = ($urandom % 4) != 0;
            pv = ($urandom % 4) != 0;
            en = ($urandom % 8) != 0;
            rv = ($urandom % 3) == 0;
            rd = (mq.size() > 0 && ($urandom % 5) != 0) ? mq[0] : int'($urandom % 256);
            dn = ($urandom % 3) == 0;
            step(0, lv[0], pv[0], en[0], int'($urandom % 65536),
                 int'($urandom % 256), rv[0], rd, dn[0]);
        end
        idle(1);
        idle(0);
        repeat (3) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        check("spec_queue_drained", spec_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
